// File: rtl/contador_param.sv
// Up/down/step counter with parallel load and cascade carry chain.
// Q and RCO are registered and change on the clock edge; CO is combinational, so a stage feeds the next one in the same cycle.
module contador_param #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic             CI,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             CO
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DOWN = 2'b01;
    localparam logic [1:0] MODO_STEP = 2'b10;
    localparam logic [1:0] MODO_LOAD = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    logic             advance;
    logic             load;
    logic             wrap;

    // CI gates counting only; a load always goes through.
    always_comb begin
        advance = ENB & CI & (MODO != MODO_LOAD);
        load    = ENB & (MODO == MODO_LOAD);
    end

    always_comb begin
        wrap = 1'b0;
        case (MODO)
            MODO_UP:   wrap = (q_q == {WIDTH{1'b1}});
            MODO_DOWN: wrap = (q_q == '0);
            MODO_STEP: wrap = (q_q < STEP_W);
            default:   wrap = 1'b0;
        endcase
    end

    always_comb begin
        q_d   = q_q;
        rco_d = rco_q;
        if (load) begin
            q_d   = D;
            rco_d = 1'b0;
        end else if (ENB) begin
            rco_d = advance & wrap;
            if (advance) begin
                case (MODO)
                    MODO_UP:   q_d = q_q + 1'b1;
                    MODO_DOWN: q_d = q_q - 1'b1;
                    MODO_STEP: q_d = q_q - STEP_W;
                    default:   q_d = q_q;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_q   <= '0;
            rco_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            rco_q <= rco_d;
        end
    end

    assign Q   = q_q;
    assign RCO = rco_q;
    assign CO  = advance & wrap;

endmodule

// File: tb/tb_contador_param.sv
// Scoreboarded bench for contador_param: a standalone 4-bit stage, a two-stage cascade and an 8-bit stage.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares one record per cycle.
module tb_contador_param;

    logic CLK;
    logic RESET;

    logic       a_enb, a_ci;
    logic [1:0] a_modo;
    logic [3:0] a_d, a_q;
    logic       a_rco, a_co;

    logic       c_enb;
    logic [1:0] c_modo;
    logic [7:0] c_d;
    logic [3:0] c_q_lo, c_q_hi;
    logic       c_rco_lo, c_rco_hi, c_co_lo, c_co_hi;

    logic       b_enb, b_ci;
    logic [1:0] b_modo;
    logic [7:0] b_d, b_q;
    logic       b_rco, b_co;

    contador_param #(.WIDTH(4), .STEP(3)) u_a (
        .CLK(CLK), .RESET(RESET), .ENB(a_enb), .CI(a_ci), .MODO(a_modo),
        .D(a_d), .Q(a_q), .RCO(a_rco), .CO(a_co)
    );

    contador_param #(.WIDTH(4), .STEP(3)) u_c_lo (
        .CLK(CLK), .RESET(RESET), .ENB(c_enb), .CI(1'b1), .MODO(c_modo),
        .D(c_d[3:0]), .Q(c_q_lo), .RCO(c_rco_lo), .CO(c_co_lo)
    );

    contador_param #(.WIDTH(4), .STEP(3)) u_c_hi (
        .CLK(CLK), .RESET(RESET), .ENB(c_enb), .CI(c_co_lo), .MODO(c_modo),
        .D(c_d[7:4]), .Q(c_q_hi), .RCO(c_rco_hi), .CO(c_co_hi)
    );

    contador_param #(.WIDTH(8), .STEP(5)) u_b (
        .CLK(CLK), .RESET(RESET), .ENB(b_enb), .CI(b_ci), .MODO(b_modo),
        .D(b_d), .Q(b_q), .RCO(b_rco), .CO(b_co)
    );

    typedef struct {
        string       name;
        int          unit;
        logic [15:0] q;
        logic        rco;
        logic        co;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Monitor: one record per cycle, sampled on the falling edge.
    initial begin
        exp_t        e;
        logic [15:0] act_q;
        logic        act_rco, act_co;
        forever begin
            @(negedge CLK);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                case (e.unit)
                    0: begin act_q = 16'(a_q);            act_rco = a_rco;    act_co = a_co;    end
                    1: begin act_q = {8'h00, c_q_hi, c_q_lo}; act_rco = c_rco_hi; act_co = c_co_hi; end
                    default: begin act_q = 16'(b_q);       act_rco = b_rco;    act_co = b_co;    end
                endcase
                n_tests += 3;
                if (act_q !== e.q) begin
                    n_fail++;
                    $display("FAIL %s Q: got %0h expected %0h", e.name, act_q, e.q);
                end
                if (act_rco !== e.rco) begin
                    n_fail++;
                    $display("FAIL %s RCO: got %b expected %b", e.name, act_rco, e.rco);
                end
                if (act_co !== e.co) begin
                    n_fail++;
                    $display("FAIL %s CO: got %b expected %b", e.name, act_co, e.co);
                end
            end
        end
    end

    task automatic expect_rec(input string nm, input int unit, input logic [15:0] q,
                              input logic rco, input logic co);
        exp_t e;
        e.name = nm; e.unit = unit; e.q = q; e.rco = rco; e.co = co;
        sb.push_back(e);
    endtask

    task automatic step_a(input logic e, input logic ci, input logic [1:0] m, input logic [3:0] d,
                          input logic [3:0] eq, input logic er, input logic ec, input string nm);
        @(negedge CLK); #1;
        a_enb = e; a_ci = ci; a_modo = m; a_d = d;
        expect_rec(nm, 0, 16'(eq), er, ec);
    endtask

    task automatic step_c(input logic e, input logic [1:0] m, input logic [7:0] d,
                          input logic [7:0] eq, input logic er, input logic ec, input string nm);
        @(negedge CLK); #1;
        c_enb = e; c_modo = m; c_d = d;
        expect_rec(nm, 1, 16'(eq), er, ec);
    endtask

    task automatic step_b(input logic e, input logic ci, input logic [1:0] m, input logic [7:0] d,
                          input logic [7:0] eq, input logic er, input logic ec, input string nm);
        @(negedge CLK); #1;
        b_enb = e; b_ci = ci; b_modo = m; b_d = d;
        expect_rec(nm, 2, 16'(eq), er, ec);
    endtask

    initial begin
        int guard;
        RESET = 1'b1;
        a_enb = 1'b0; a_ci = 1'b0; a_modo = 2'b00; a_d = 4'h0;
        c_enb = 1'b0; c_modo = 2'b00; c_d = 8'h00;
        b_enb = 1'b0; b_ci = 1'b0; b_modo = 2'b00; b_d = 8'h00;

        repeat (2) @(negedge CLK);
        #1;
        expect_rec("reset_state", 0, 16'h0, 1'b0, 1'b0);
        @(negedge CLK); #1;
        RESET = 1'b0;

        // Up count through the wrap.
        for (int k = 1; k <= 16; k++)
            step_a(1'b1, 1'b1, 2'b00, 4'h0, 4'(k), (k == 16), (k == 15), "up_wrap");

        // Down by STEP from 5.
        step_a(1'b1, 1'b1, 2'b11, 4'h5, 4'h5, 1'b0, 1'b0, "load5");
        step_a(1'b1, 1'b1, 2'b10, 4'h0, 4'h2, 1'b0, 1'b1, "step_5to2");
        step_a(1'b1, 1'b1, 2'b10, 4'h0, 4'hF, 1'b1, 1'b0, "step_2to15");
        step_a(1'b1, 1'b1, 2'b10, 4'h0, 4'hC, 1'b0, 1'b0, "step_15to12");

        // RCO holds through ENB=0, then clears on an enabled non-advancing edge.
        step_a(1'b1, 1'b1, 2'b11, 4'hE, 4'hE, 1'b0, 1'b0, "loadE");
        step_a(1'b1, 1'b1, 2'b00, 4'h0, 4'hF, 1'b0, 1'b1, "up_to15");
        step_a(1'b1, 1'b1, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0, "up_wrap0");
        step_a(1'b0, 1'b1, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0, "enb0_hold_rco1");
        step_a(1'b0, 1'b1, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0, "enb0_hold_rco2");
        step_a(1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, "ci0_hold");
        step_a(1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 1'b0, 1'b0, "ci0_no_co");

        // Load with CI=0, then freeze for three edges.
        step_a(1'b1, 1'b0, 2'b11, 4'hA, 4'hA, 1'b0, 1'b0, "loadA_ci0");
        for (int k = 0; k < 3; k++)
            step_a(1'b0, 1'b1, 2'b00, 4'h3, 4'hA, 1'b0, 1'b0, "enb0_holdA");
        @(negedge CLK); #1;
        a_enb = 1'b0;

        // Two-stage cascade.
        step_c(1'b1, 2'b11, 8'h0F, 8'h0F, 1'b0, 1'b0, "casc_load0F");
        step_c(1'b1, 2'b00, 8'h00, 8'h10, 1'b0, 1'b0, "casc_0Fto10");
        step_c(1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0, 1'b0, "casc_loadFF");
        step_c(1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, "casc_FFto00");
        step_c(1'b1, 2'b00, 8'h00, 8'h01, 1'b0, 1'b0, "casc_00to01");
        @(negedge CLK); #1;
        c_enb = 1'b0;

        // 8-bit stage, STEP=5.
        step_b(1'b1, 1'b1, 2'b01, 8'h00, 8'hFF, 1'b1, 1'b0, "w8_down_wrap");
        step_b(1'b1, 1'b1, 2'b01, 8'h00, 8'hFE, 1'b0, 1'b0, "w8_down");
        step_b(1'b1, 1'b1, 2'b11, 8'h09, 8'h09, 1'b0, 1'b0, "w8_load9");
        step_b(1'b1, 1'b1, 2'b10, 8'h00, 8'h04, 1'b0, 1'b1, "w8_step_9to4");
        step_b(1'b1, 1'b1, 2'b10, 8'h00, 8'hFF, 1'b1, 1'b0, "w8_step_4to255");
        @(negedge CLK); #1;
        b_enb = 1'b0;

        // Asynchronous reset between edges while Q=7 and frozen.
        step_a(1'b1, 1'b1, 2'b11, 4'h6, 4'h6, 1'b0, 1'b0, "load6");
        step_a(1'b1, 1'b1, 2'b00, 4'h0, 4'h7, 1'b0, 1'b0, "up_to7");
        step_a(1'b0, 1'b1, 2'b00, 4'h0, 4'h7, 1'b0, 1'b0, "hold7");
        @(negedge CLK);
        @(posedge CLK); #2;
        RESET = 1'b1;
        expect_rec("async_rst", 0, 16'h0, 1'b0, 1'b0);
        step_a(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0, 1'b1, "rst_co_down");
        @(negedge CLK); #1;
        RESET = 1'b0;
        expect_rec("rst_release_down", 0, 16'hF, 1'b1, 1'b0);

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d records left, expected 0", sb.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_param.md
CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter STEP, default 3: decrement for MODO=10; legal range 1..2^WIDTH-1.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 ENB  input  1  global enable; low freezes all registered state.
REQ-006 CI  input  1  cascade count-enable from the lower stage; tie high on a standalone or least-significant stage.
REQ-007 MODO  input  2  mode select: 00 up by 1; 01 down by 1; 10 down by STEP; 11 parallel load.
REQ-008 D  input  WIDTH  parallel load data.
REQ-009 Q  output  WIDTH  registered count.
REQ-010 RCO  output  1  registered ripple-carry/borrow flag.
REQ-011 CO  output  1  combinational cascade carry-out, for the CI of the next-higher stage.

Function
REQ-012 advance = ENB & CI & (MODO != 11); load = ENB & (MODO == 11), with CI ignored.
REQ-013 wrap condition, a combinational function of Q and MODO:
- MODO=00: Q == 2^WIDTH-1.
- MODO=01: Q == 0.
- MODO=10: Q < STEP.
- MODO=11: 0.
REQ-014 On a rising edge with advance=1, Q SHALL update as follows, all arithmetic modulo 2^WIDTH with no saturation:
- MODO=00: Q <= Q+1.
- MODO=01: Q <= Q-1.
- MODO=10: Q <= Q-STEP.
REQ-015 On a rising edge with load=1, Q <= D, irrespective of CI.
REQ-016 On a rising edge with ENB=1, CI=0 and MODO != 11, Q holds.
REQ-017 On any rising edge with ENB=0, Q and RCO hold their values.
REQ-018 On every rising edge with ENB=1, RCO <= advance & wrap; RCO is therefore a one-cycle pulse coincident with the wrapped Q value.
REQ-019 A load edge SHALL clear RCO to 0.
REQ-020 CO = advance & wrap, purely combinational with zero latency; CO is 0 whenever ENB=0, CI=0 or MODO=11.
REQ-021 Cascading N instances on the same CLK (CO of stage k to CI of stage k+1, with shared MODO and ENB) SHALL form one synchronous N*WIDTH-bit counter for MODO 00 and 01; no derived or gated clocks are used.
REQ-022 Cascaded MODO=10 is undefined beyond stage 0; this is documented behaviour and not an error.
REQ-023 A MODO change takes effect on the next edge; the wrap condition and CO reflect the new MODO combinationally.
REQ-024 No latches; every combinational output is fully assigned in every mode.

Reset
REQ-025 While RESET=1, Q SHALL be 0 and RCO SHALL be 0, asynchronously and regardless of CLK and ENB.
REQ-026 RESET asserted mid-count aborts the operation immediately; no pending RCO pulse survives.
REQ-027 After RESET deasserts, the first rising edge evaluates normally from Q=0.
REQ-028 CO SHALL be 0 during reset, except when MODO=01 or 10 with ENB=CI=1, in which case CO=1 because Q=0 wraps.

Verification
REQ-029 Up-count wrap: WIDTH=4, MODO=00, ENB=CI=1, from reset -> Q steps 0..15 then 0; CO=1 while Q=15; RCO=1 only in the cycle Q=0 after the wrap.
REQ-030 Down-by-STEP: WIDTH=4, STEP=3, load D=5, then MODO=10 -> Q sequence 5, 2, 15 (2-3 mod 16), 12; RCO=1 with Q=15 only; CO=1 while Q=2.
REQ-031 Load and hold: MODO=11 with D=0xA and CI=0 -> Q=0xA on the next edge and RCO=0; ENB=0 for 3 edges -> Q=0xA held and RCO unchanged.
REQ-032 Cascade: two WIDTH=4 stages, MODO=00, loaded to 0x0F then counted -> 0x10 after one edge; from 0xFF -> 0x00 with upper-stage RCO=1 for exactly one cycle.
REQ-033 Async reset: assert RESET between clock edges while Q=7 -> Q=0 and RCO=0 without waiting for an edge; deassert, MODO=01 -> Q=2^WIDTH-1 and RCO=1 on the first edge.
REQ-034 Parameter sweep: WIDTH=8, STEP=5, MODO=01 from Q=0 -> Q=255 and RCO pulse; MODO=10 from Q=4 -> Q=255 and CO=1 beforehand.
